// File: rtl/regfile_2r1w_if.sv
// Write/read bus of the 2R1W register file: one write port, two read ports.
// The master drives addresses and write data; the register file returns read data.
interface regfile_2r1w_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [N-1:0]      wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [N-1:0]      rdata_a;
  logic [N-1:0]      rdata_b;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b
  );
endinterface

// File: rtl/regfile_2r1w.sv
// 2**ADDR_W x N register file with one synchronous write port and two registered
// read ports; a read of the word being written on the same edge returns the new data.
module regfile_2r1w #(
  parameter int N        = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_2r1w_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][N-1:0] r_mem;
  logic [N-1:0]            r_rdata_a;
  logic [N-1:0]            r_rdata_b;

  logic                    w_wr_en;
  logic [N-1:0]            w_rd_a;
  logic [N-1:0]            w_rd_b;

  // A suppressed write to word 0 must neither update storage nor forward.
  assign w_wr_en = bus.we && !((ZERO_REG != 0) && (bus.waddr == '0));

  assign w_rd_a = (w_wr_en && (bus.waddr == bus.raddr_a)) ? bus.wdata : r_mem[bus.raddr_a];
  assign w_rd_b = (w_wr_en && (bus.waddr == bus.raddr_b)) ? bus.wdata : r_mem[bus.raddr_b];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
    end else if (w_wr_en) begin
      r_mem[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      r_rdata_a <= w_rd_a;
      r_rdata_b <= w_rd_b;
    end
  end

  assign bus.rdata_a = r_rdata_a;
  assign bus.rdata_b = r_rdata_b;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: drives one instance with ZERO_REG=1 and one with ZERO_REG=0
// from the same stimulus and checks both against an array model every cycle.
module tb_regfile_2r1w;
  localparam int N      = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_2r1w_if #(.N(N), .ADDR_W(ADDR_W)) if_z ();
  regfile_2r1w_if #(.N(N), .ADDR_W(ADDR_W)) if_n ();

  regfile_2r1w #(.N(N), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut_z (.clk(clk), .rst(rst), .bus(if_z));
  regfile_2r1w #(.N(N), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut_n (.clk(clk), .rst(rst), .bus(if_n));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: storage as plain arrays; a read on an edge returns the state after that
  // edge's write, which is exactly what read-during-write forwarding means.
  logic [N-1:0] m_z [DEPTH];
  logic [N-1:0] m_n [DEPTH];
  logic [N-1:0] e_za, e_zb, e_na, e_nb;

  always @(posedge clk or posedge rst) begin : model
    logic [N-1:0] t_z [DEPTH];
    logic [N-1:0] t_n [DEPTH];
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_z[k] <= '0;
        m_n[k] <= '0;
      end
      e_za <= '0; e_zb <= '0; e_na <= '0; e_nb <= '0;
    end else begin
      t_z = m_z;
      t_n = m_n;
      if (if_n.we) begin
        t_n[if_n.waddr] = if_n.wdata;
        if (if_z.waddr != 0) t_z[if_z.waddr] = if_z.wdata;
      end
      m_z  <= t_z;
      m_n  <= t_n;
      e_za <= t_z[if_z.raddr_a];
      e_zb <= t_z[if_z.raddr_b];
      e_na <= t_n[if_n.raddr_a];
      e_nb <= t_n[if_n.raddr_b];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_z_a", if_z.rdata_a, e_za);
      chk("model_z_b", if_z.rdata_b, e_zb);
      chk("model_n_a", if_n.rdata_a, e_na);
      chk("model_n_b", if_n.rdata_b, e_nb);
    end
  end

  task automatic drive(input logic we, input int wa, input logic [N-1:0] wd,
                       input int ra, input int rb);
    if_z.we = we; if_z.waddr = ADDR_W'(wa); if_z.wdata = wd;
    if_z.raddr_a = ADDR_W'(ra); if_z.raddr_b = ADDR_W'(rb);
    if_n.we = we; if_n.waddr = ADDR_W'(wa); if_n.wdata = wd;
    if_n.raddr_a = ADDR_W'(ra); if_n.raddr_b = ADDR_W'(rb);
  endtask

  // Apply inputs, take one rising edge, land 1 time unit after it.
  task automatic cyc(input logic we, input int wa, input logic [N-1:0] wd,
                     input int ra, input int rb);
    drive(we, wa, wd, ra, rb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 0, '0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", if_z.rdata_a, 32'h0);
    chk("reset_b", if_n.rdata_b, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Write then mid-cycle reset clears storage and outputs at once.
    cyc(1'b1, 3, 32'hDEADBEEF, 3, 3);
    chk("fwd_w3", if_z.rdata_a, 32'hDEADBEEF);
    drive(1'b0, 0, '0, 3, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_z", if_z.rdata_a, 32'h0);
    chk("async_rst_n", if_n.rdata_a, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 0, '0, 3, 3);
    chk("post_rst_w3", if_z.rdata_a, 32'h0);

    // Basic write then read on both ports.
    cyc(1'b1, 7, 32'h12345678, 0, 0);
    cyc(1'b0, 0, '0, 7, 7);
    chk("rd7_a", if_z.rdata_a, 32'h12345678);
    chk("rd7_b", if_z.rdata_b, 32'h12345678);

    // Forwarding on port A only; port B sees word 8's old contents.
    cyc(1'b1, 9, 32'h1, 0, 0);
    cyc(1'b1, 8, 32'h88, 0, 0);
    cyc(1'b1, 9, 32'hA5A5A5A5, 9, 8);
    chk("fwd9_a", if_z.rdata_a, 32'hA5A5A5A5);
    chk("old8_b", if_z.rdata_b, 32'h88);

    // Word 0 behaviour under both ZERO_REG settings.
    cyc(1'b1, 0, 32'hFFFFFFFF, 0, 0);
    chk("zr1_w0_fwd", if_z.rdata_a, 32'h0);
    chk("zr0_w0_fwd", if_n.rdata_a, 32'hFFFFFFFF);
    cyc(1'b0, 0, '0, 0, 0);
    chk("zr1_w0_rd", if_z.rdata_a, 32'h0);
    chk("zr0_w0_rd", if_n.rdata_a, 32'hFFFFFFFF);

    // we=0 leaves word 4 untouched.
    cyc(1'b0, 4, 32'h55, 4, 4);
    chk("we0_fwd", if_z.rdata_a, 32'h0);
    cyc(1'b0, 0, '0, 4, 4);
    chk("we0_w4", if_z.rdata_b, 32'h0);

    // Sweep: fill 1..31, read A ascending and B descending.
    for (int i = 1; i < DEPTH; i++) cyc(1'b1, i, N'(i) * 32'h01010101, 0, 0);
    for (int i = 1; i < DEPTH; i++) begin
      cyc(1'b0, 0, '0, i, DEPTH - i);
      chk("sweep_a", if_z.rdata_a, N'(i) * 32'h01010101);
      chk("sweep_b", if_z.rdata_b, N'(DEPTH - i) * 32'h01010101);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
